// File: rtl/tone_arbiter_pkg.sv
// Shared widths, state encoding and requester indices for the tone arbiter.
package tone_arbiter_pkg;

  localparam int unsigned PITCH_W = 18;
  localparam int unsigned DUR_W   = 5;
  localparam int unsigned TICK_W  = 23;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Index NREQ-1 wins arbitration, so score outranks everything else.
  localparam int unsigned REQ_PADDLE = 0;
  localparam int unsigned REQ_WALL   = 1;
  localparam int unsigned REQ_MISS   = 2;
  localparam int unsigned REQ_SCORE  = 3;

endpackage

// File: rtl/tone_arbiter_if.sv
// Game-logic side bundle of the tone arbiter: request strobes and slots in,
// pitch and status out.
interface tone_arbiter_if #(
  parameter int unsigned NREQ = 4
);
  import tone_arbiter_pkg::*;

  localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]         req;
  logic [NREQ*PITCH_W-1:0] pitch_in;
  logic [NREQ*DUR_W-1:0]   dur_in;
  logic                    mute;
  logic [PITCH_W-1:0]      pitch;
  logic                    playing;
  logic [IDW-1:0]          grant_id;
  logic                    done;
  logic                    aborted;

  modport master (
    output req, pitch_in, dur_in, mute,
    input  pitch, playing, grant_id, done, aborted
  );

  modport slave (
    input  req, pitch_in, dur_in, mute,
    output pitch, playing, grant_id, done, aborted
  );

endinterface

// File: rtl/tone_arbiter_timer.sv
// Tick/eighth counter pair; expire is high in the last cycle of the loaded span.
// The gap reuses the same counters as a single unit with the gap tick limit.
module tone_arbiter_timer
  import tone_arbiter_pkg::*;
#(
  parameter int unsigned TICK_LIM = 6_250_000,
  parameter int unsigned GAP_LIM  = 1_250_000
) (
  input  logic             clk50,
  input  logic             reset,
  input  logic             load,
  input  logic             gap,
  input  logic [DUR_W-1:0] dur,
  output logic             expire
);

  logic [TICK_W-1:0] tick;
  logic [TICK_W-1:0] lim_m1;
  logic [DUR_W-1:0]  eighth;
  logic [DUR_W-1:0]  dur_q;
  logic              gap_q;
  logic              active;
  logic              tick_last;

  always_comb begin
    lim_m1    = gap_q ? TICK_W'(GAP_LIM - 1) : TICK_W'(TICK_LIM - 1);
    tick_last = (tick == lim_m1);
    expire    = active && tick_last && (eighth == (dur_q - DUR_W'(1)));
  end

  always_ff @(posedge clk50) begin
    if (reset) begin
      tick   <= '0;
      eighth <= '0;
      dur_q  <= '0;
      gap_q  <= 1'b0;
      active <= 1'b0;
    end else if (load) begin
      tick   <= '0;
      eighth <= '0;
      dur_q  <= gap ? DUR_W'(1) : dur;
      gap_q  <= gap;
      active <= 1'b1;
    end else if (active) begin
      if (expire) begin
        tick   <= '0;
        eighth <= '0;
        active <= 1'b0;
      end else if (tick_last) begin
        tick   <= '0;
        eighth <= eighth + DUR_W'(1);
      end else begin
        tick <= tick + TICK_W'(1);
      end
    end
  end

endmodule

// File: rtl/tone_arbiter.sv
// Shares one timed tone output between prioritised sound events, with a silent
// gap after every naturally completed tone and optional higher-priority preemption.
//
// state | meaning
// IDLE  | nothing playing, waiting for a pending request
// PLAY  | driving cur_pitch for the granted duration
// GAP   | forced silence before the next tone
module tone_arbiter
  import tone_arbiter_pkg::*;
#(
  parameter int unsigned NREQ         = 4,
  parameter int unsigned EIGHTH_TICKS = 6_250_000,
  parameter int unsigned GAP_TICKS    = 1_250_000,
  parameter bit          PREEMPT      = 1'b1
) (
  input logic           clk50,
  input logic           reset,
  tone_arbiter_if.slave bus
);

  localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t             state;
  logic [NREQ-1:0]    pend;
  logic [NREQ-1:0]    cap;
  logic [NREQ-1:0]    consume;
  logic [PITCH_W-1:0] slot_pitch [NREQ];
  logic [DUR_W-1:0]   slot_dur   [NREQ];
  logic [PITCH_W-1:0] cur_pitch;
  logic [PITCH_W-1:0] pitch_q;
  logic [IDW-1:0]     win;
  logic [IDW-1:0]     grant_q;
  logic               pend_any;
  logic               take;
  logic               to_gap;
  logic               expire;
  logic               playing_q;
  logic               done_q;
  logic               aborted_q;

  always_comb begin
    win      = '0;
    pend_any = 1'b0;
    cap      = '0;
    for (int i = 0; i < NREQ; i++) begin
      cap[i] = bus.req[i] && (bus.dur_in[i*DUR_W +: DUR_W] != '0);
      if (pend[i]) begin
        win      = IDW'(i);
        pend_any = 1'b1;
      end
    end
  end

  // Natural expiry beats preemption when both land in the same cycle.
  always_comb begin
    take   = 1'b0;
    to_gap = 1'b0;
    case (state)
      IDLE: take = pend_any;
      PLAY: begin
        if (expire) to_gap = 1'b1;
        else if (PREEMPT && pend_any && (win > grant_q)) take = 1'b1;
      end
      GAP:  take = expire && pend_any;
      default: ;
    endcase
    consume = take ? (NREQ'(1) << win) : '0;
  end

  tone_arbiter_timer #(
    .TICK_LIM (EIGHTH_TICKS),
    .GAP_LIM  (GAP_TICKS)
  ) u_timer (
    .clk50  (clk50),
    .reset  (reset),
    .load   (take | to_gap),
    .gap    (to_gap),
    .dur    (slot_dur[win]),
    .expire (expire)
  );

  // A capture in the same cycle as consumption keeps the slot pending.
  always_ff @(posedge clk50) begin
    if (reset) begin
      pend <= '0;
      for (int i = 0; i < NREQ; i++) begin
        slot_pitch[i] <= '0;
        slot_dur[i]   <= '0;
      end
    end else begin
      pend <= (pend & ~consume) | cap;
      for (int i = 0; i < NREQ; i++) begin
        if (cap[i]) begin
          slot_pitch[i] <= bus.pitch_in[i*PITCH_W +: PITCH_W];
          slot_dur[i]   <= bus.dur_in[i*DUR_W +: DUR_W];
        end
      end
    end
  end

  always_ff @(posedge clk50) begin
    if (reset) begin
      state     <= IDLE;
      cur_pitch <= '0;
      pitch_q   <= '0;
      playing_q <= 1'b0;
      grant_q   <= '0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      if (take) begin
        state     <= PLAY;
        grant_q   <= win;
        cur_pitch <= slot_pitch[win];
        pitch_q   <= bus.mute ? '0 : slot_pitch[win];
        playing_q <= 1'b1;
        aborted_q <= (state == PLAY);
      end else if (to_gap) begin
        state     <= GAP;
        pitch_q   <= '0;
        playing_q <= 1'b0;
        done_q    <= 1'b1;
      end else if (state == GAP && expire) begin
        state <= IDLE;
      end else if (state == PLAY) begin
        pitch_q <= bus.mute ? '0 : cur_pitch;
      end
    end
  end

  assign bus.pitch    = pitch_q;
  assign bus.playing  = playing_q;
  assign bus.grant_id = grant_q;
  assign bus.done     = done_q;
  assign bus.aborted  = aborted_q;

endmodule

// File: tb/tb_tone_arbiter.sv
// Bench for tone_arbiter: directed scenarios with fixed expectations, then
// random traffic against an event-level reference model.
module tb_tone_arbiter;

  localparam int E = 4;
  localparam int G = 2;

  logic clk50 = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  tone_arbiter_if #(.NREQ(4)) bus ();

  tone_arbiter #(
    .NREQ(4), .EIGHTH_TICKS(E), .GAP_TICKS(G), .PREEMPT(1'b1)
  ) dut (
    .clk50 (clk50),
    .reset (reset),
    .bus   (bus)
  );

  always #10 clk50 = ~clk50;

  logic [22:0] obs;
  assign obs = {bus.pitch, bus.playing, bus.grant_id, bus.done, bus.aborted};

  function automatic logic [22:0] ex(input logic [17:0] p, input logic pl,
                                     input logic [1:0] g, input logic d, input logic a);
    return {p, pl, g, d, a};
  endfunction

  task automatic tick();
    @(posedge clk50);
    #1;
  endtask

  task automatic set_req(input int i, input logic [17:0] p, input logic [4:0] d);
    bus.req[i] = 1'b1;
    bus.pitch_in[i*18 +: 18] = p;
    bus.dur_in[i*5 +: 5] = d;
  endtask

  task automatic clr_req();
    bus.req = '0;
  endtask

  // Reference model: remaining-cycle countdown per phase, pending table per requester.
  int          m_st;   // 0 idle, 1 tone, 2 gap
  int          m_rem;
  int          m_gid;
  logic [17:0] m_cur;
  bit          m_pend [4];
  logic [17:0] m_sp [4];
  int          m_sd [4];
  logic [17:0] e_pitch;
  bit          e_play, e_done, e_abort;

  function automatic void model_reset();
    m_st = 0; m_rem = 0; m_gid = 0; m_cur = '0;
    for (int i = 0; i < 4; i++) begin m_pend[i] = 0; m_sp[i] = '0; m_sd[i] = 0; end
    e_pitch = '0; e_play = 0; e_done = 0; e_abort = 0;
  endfunction

  function automatic void model_step(input logic [3:0] rq, input logic [71:0] pin,
                                     input logic [19:0] din, input logic mt);
    int w;
    bit take, stop;
    w = -1;
    for (int i = 0; i < 4; i++) if (m_pend[i]) w = i;
    take = 0; stop = 0; e_done = 0; e_abort = 0;
    if (m_st == 0) take = (w >= 0);
    else if (m_st == 1) begin
      if (m_rem == 1) stop = 1;
      else if (w > m_gid) take = 1;
    end else if (m_rem == 1) begin
      if (w >= 0) take = 1;
      else m_st = 0;
    end
    if (take) begin
      e_abort = (m_st == 1);
      m_st = 1; m_gid = w; m_cur = m_sp[w]; m_rem = m_sd[w] * E; m_pend[w] = 0;
    end else if (stop) begin
      m_st = 2; m_rem = G; e_done = 1;
    end else if (m_st != 0) begin
      m_rem--;
    end
    for (int i = 0; i < 4; i++) begin
      if (rq[i] && din[i*5 +: 5] != 0) begin
        m_pend[i] = 1; m_sp[i] = pin[i*18 +: 18]; m_sd[i] = int'(din[i*5 +: 5]);
      end
    end
    e_play  = (m_st == 1);
    e_pitch = (m_st == 1 && !mt) ? m_cur : '0;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    set_req(3, 18'h3FFFF, 5'd1);
    tick();
    vectors++;
    if (obs !== ex(0, 0, 0, 0, 0)) begin
      miscompares++; $display("FAIL reset_state: got %h want %h", obs, ex(0, 0, 0, 0, 0));
    end
    reset = 1'b0;
    clr_req();
    for (int c = 0; c < 3; c++) begin
      tick();
      vectors++;
      if (obs !== ex(0, 0, 0, 0, 0)) begin
        miscompares++; $display("FAIL reset_discard c%0d: got %h want %h", c, obs, ex(0, 0, 0, 0, 0));
      end
    end
  endtask

  task automatic test_single();
    set_req(1, 18'h1234, 5'd2);
    tick();
    clr_req();
    vectors++;
    if (obs !== ex(0, 0, 0, 0, 0)) begin
      miscompares++; $display("FAIL single_latency: got %h want %h", obs, ex(0, 0, 0, 0, 0));
    end
    for (int c = 0; c < 8; c++) begin
      tick();
      vectors++;
      if (obs !== ex(18'h1234, 1, 1, 0, 0)) begin
        miscompares++; $display("FAIL single_play c%0d: got %h want %h", c, obs, ex(18'h1234, 1, 1, 0, 0));
      end
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      vectors++;
      if (obs !== ex(0, 0, 1, (c == 0), 0)) begin
        miscompares++; $display("FAIL single_gap c%0d: got %h want %h", c, obs, ex(0, 0, 1, (c == 0), 0));
      end
    end
  endtask

  task automatic test_simultaneous();
    set_req(0, 18'h0AAA, 5'd1);
    set_req(2, 18'h0BBB, 5'd1);
    tick();
    clr_req();
    for (int c = 0; c < 15; c++) begin
      logic [22:0] w;
      tick();
      if (c < 4)       w = ex(18'h0BBB, 1, 2, 0, 0);
      else if (c < 6)  w = ex(0, 0, 2, (c == 4), 0);
      else if (c < 10) w = ex(18'h0AAA, 1, 0, 0, 0);
      else             w = ex(0, 0, 0, (c == 10), 0);
      vectors++;
      if (obs !== w) begin
        miscompares++; $display("FAIL simultaneous c%0d: got %h want %h", c, obs, w);
      end
    end
  endtask

  task automatic test_preempt();
    set_req(0, 18'h0111, 5'd3);
    tick();
    clr_req();
    for (int c = 1; c <= 18; c++) begin
      logic [22:0] w;
      tick();
      if (c == 6) clr_req();
      if (c <= 6)       w = ex(18'h0111, 1, 0, 0, 0);
      else if (c <= 10) w = ex(18'h3333, 1, 3, 0, (c == 7));
      else              w = ex(0, 0, 3, (c == 11), 0);
      vectors++;
      if (obs !== w) begin
        miscompares++; $display("FAIL preempt c%0d: got %h want %h", c, obs, w);
      end
      if (c == 5) set_req(3, 18'h3333, 5'd1);
    end
  endtask

  task automatic test_no_preempt();
    set_req(3, 18'h3A3A, 5'd2);
    tick();
    clr_req();
    for (int c = 1; c <= 17; c++) begin
      logic [22:0] w;
      tick();
      if (c == 4) clr_req();
      if (c <= 8)       w = ex(18'h3A3A, 1, 3, 0, 0);
      else if (c <= 10) w = ex(0, 0, 3, (c == 9), 0);
      else if (c <= 14) w = ex(18'h1B1B, 1, 1, 0, 0);
      else              w = ex(0, 0, 1, (c == 15), 0);
      vectors++;
      if (obs !== w) begin
        miscompares++; $display("FAIL no_preempt c%0d: got %h want %h", c, obs, w);
      end
      if (c == 3) set_req(1, 18'h1B1B, 5'd1);
    end
  endtask

  task automatic test_zero_mute();
    set_req(2, 18'h2222, 5'd0);
    tick();
    clr_req();
    for (int c = 0; c < 3; c++) begin
      tick();
      vectors++;
      if (obs !== ex(0, 0, 1, 0, 0)) begin
        miscompares++; $display("FAIL zero_dur c%0d: got %h want %h", c, obs, ex(0, 0, 1, 0, 0));
      end
    end
    bus.mute = 1'b1;
    set_req(2, 18'h2222, 5'd1);
    tick();
    clr_req();
    for (int c = 0; c < 7; c++) begin
      logic [22:0] w;
      tick();
      if (c == 3) bus.mute = 1'b0;
      w = (c < 4) ? ex(0, 1, 2, 0, 0) : ex(0, 0, 2, (c == 4), 0);
      vectors++;
      if (obs !== w) begin
        miscompares++; $display("FAIL mute c%0d: got %h want %h", c, obs, w);
      end
    end
  endtask

  task automatic test_reset_mid();
    set_req(2, 18'h2C2C, 5'd2);
    tick();
    clr_req();
    tick();
    set_req(0, 18'h0101, 5'd1);
    tick();
    clr_req();
    vectors++;
    if (obs !== ex(18'h2C2C, 1, 2, 0, 0)) begin
      miscompares++; $display("FAIL reset_mid_play: got %h want %h", obs, ex(18'h2C2C, 1, 2, 0, 0));
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      vectors++;
      if (obs !== ex(0, 0, 0, 0, 0)) begin
        miscompares++; $display("FAIL reset_mid c%0d: got %h want %h", c, obs, ex(0, 0, 0, 0, 0));
      end
      tick();
    end
  endtask

  task automatic test_random();
    reset = 1'b1;
    tick();
    model_reset();
    reset = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 4; i++) begin
        bus.req[i] = ($urandom_range(0, 9) == 0);
        bus.pitch_in[i*18 +: 18] = 18'($urandom);
        bus.dur_in[i*5 +: 5] = 5'($urandom_range(0, 3));
      end
      bus.mute = ($urandom_range(0, 15) == 0);
      @(posedge clk50);
      model_step(bus.req, bus.pitch_in, bus.dur_in, bus.mute);
      #1;
      vectors++;
      if (obs !== ex(e_pitch, e_play, 2'(m_gid), e_done, e_abort)) begin
        miscompares++;
        $display("FAIL random c%0d: got %h want %h", c, obs, ex(e_pitch, e_play, 2'(m_gid), e_done, e_abort));
      end
    end
    clr_req();
    bus.mute = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.req = '0;
    bus.pitch_in = '0;
    bus.dur_in = '0;
    bus.mute = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    test_reset();
    test_single();
    test_simultaneous();
    test_preempt();
    test_no_preempt();
    test_zero_mute();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
